cbus_rr_arbiter: RTL

CBUS_RR_ARBITER -- requirements
Module: cbus_rr_arbiter

---
 rtl/cbus_rr_arbiter_pkg.sv | 30 +++
 rtl/cbus_rr_arbiter_rr_select.sv | 29 ++
 rtl/cbus_rr_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/cbus_rr_arbiter_pkg.sv
// Shared types for the cbus round-robin arbiter: bus request/response
// structs, the arbiter FSM state encoding and an index wrap helper.
package cbus_rr_arbiter_pkg;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] rdata;
  } cbus_resp_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // (base + off) modulo n, used for rotating priority and pointer advance
  function automatic int unsigned rr_wrap(input int unsigned base,
                                          input int unsigned off,
                                          input int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/cbus_rr_arbiter_rr_select.sv
// rr_select: combinational rotating-base priority encoder. Returns the
// first set bit of valid searching upward from base, wrapping at NUM_INPUTS-1.
module rr_select
  import cbus_rr_arbiter_pkg::*;
#(
  parameter int NUM_INPUTS = 2,
  parameter int IDX_W      = 1
) (
  input  logic [NUM_INPUTS-1:0] valid,
  input  logic [IDX_W-1:0]      base,
  output logic                  any,
  output logic [IDX_W-1:0]      idx
);

  // Scan offsets from farthest to nearest so the nearest valid one wins
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int unsigned k = NUM_INPUTS; k > 0; k--) begin
      for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
        if (valid[i] && (i == rr_wrap(32'(base), k - 1, NUM_INPUTS))) begin
          any = 1'b1;
          idx = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// cbus_rr_arbiter: round-robin arbiter sharing one downstream cbus among
// NUM_INPUTS requesters. One transaction is outstanding at a time; the
// request is latched at grant and held until a ready+last response.
// Optional macro CBUS_ARB_BYPASS_EN adds a zero-latency grant path in IDLE.
module cbus_rr_arbiter
  import cbus_rr_arbiter_pkg::*;
#(
  parameter int NUM_INPUTS = 2,
  parameter int IDX_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  cbus_req_t        ireqs  [NUM_INPUTS],
  output cbus_resp_t       iresps [NUM_INPUTS],
  output cbus_req_t        oreq,
  input  cbus_resp_t       oresp,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  arb_state_t              state;
  logic [IDX_W-1:0]        rr_ptr;
  logic [IDX_W-1:0]        lat_idx;
  cbus_req_t               lat_req;
  logic [NUM_INPUTS-1:0]   req_valid;
  logic                    sel_any;
  logic [IDX_W-1:0]        sel_idx;
  cbus_req_t               sel_req;
  logic                    done;

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
    return IDX_W'(rr_wrap(32'(idx), 1, NUM_INPUTS));
  endfunction

  assign done = oresp.ready & oresp.last;

  // Gather valid bits and mux out the currently selected request
  always_comb begin
    req_valid = '0;
    sel_req   = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      req_valid[i] = ireqs[i].valid;
      if (IDX_W'(i) == sel_idx) begin
        sel_req = ireqs[i];
      end
    end
  end

  rr_select #(
    .NUM_INPUTS(NUM_INPUTS),
    .IDX_W     (IDX_W)
  ) u_rr_select (
    .valid(req_valid),
    .base (rr_ptr),
    .any  (sel_any),
    .idx  (sel_idx)
  );

  // Arbiter FSM: grant in IDLE, hold the latched request until completion
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      lat_idx <= '0;
      lat_req <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sel_any) begin
`ifdef CBUS_ARB_BYPASS_EN
            // A transaction finished on the bypass path never enters BUSY
            if (done) begin
              rr_ptr <= next_ptr(sel_idx);
            end else begin
              state   <= BUSY;
              lat_req <= sel_req;
              lat_idx <= sel_idx;
            end
`else
            state   <= BUSY;
            lat_req <= sel_req;
            lat_idx <= sel_idx;
`endif
          end
        end
        BUSY: begin
          // Completion only returns to IDLE; re-arbitration waits a cycle.
          // lat_idx is cleared so it doubles as the idle grant_idx of 0.
          if (done) begin
            state   <= IDLE;
            rr_ptr  <= next_ptr(lat_idx);
            lat_idx <= '0;
            lat_req <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign grant_valid = (state == BUSY);
  assign grant_idx   = lat_idx;

  // Downstream request and per-requester response routing
  always_comb begin
    oreq = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      iresps[i] = '0;
    end
    if (state == BUSY) begin
      oreq = lat_req;
      for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
        if (IDX_W'(i) == lat_idx) begin
          iresps[i] = oresp;
        end
      end
    end
`ifdef CBUS_ARB_BYPASS_EN
    else if (sel_any) begin
      oreq = sel_req;
      for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
        if (IDX_W'(i) == sel_idx) begin
          iresps[i] = oresp;
        end
      end
    end
`endif
  end

endmodule
